fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_pkg.sv | 19 +
 rtl/fifo_wr_arbiter_if.sv | 49 ++++
 rtl/fifo_wr_arbiter_rr_arbiter.sv | 56 +++++
 rtl/fifo_wr_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin FIFO write arbiter.
package fifo_pkg;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return depth + 1;
  endfunction

  // Width of a requester index.
  function automatic int unsigned gid_w(input int unsigned num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  // Reset value of the last-grant register, so requester 0 is searched first.
  function automatic int unsigned rr_reset_last(input int unsigned num_req);
    return num_req - 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/consumer/RAM-side bundle of the FIFO write arbiter.
// Optional: FIFO_ARB_UNDERFLOW_ERR_EN adds the underflow status signals.
interface fifo_wr_arbiter_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_REQ = 4
);
  import fifo_pkg::*;

  localparam int unsigned GID_W = gid_w(NUM_REQ);

  logic [NUM_REQ-1:0]       i_Req_Valid;
  logic [NUM_REQ*WIDTH-1:0] i_Req_Data;
  logic [NUM_REQ-1:0]       o_Req_Ready;
  logic                     i_RD_En;
  logic                     o_WR_En;
  logic [DEPTH-1:0]         o_WR_Addr;
  logic [WIDTH-1:0]         o_WR_Data;
  logic [DEPTH-1:0]         o_RD_Addr;
  logic                     o_Full;
  logic                     o_Empty;
  logic [DEPTH:0]           o_Count;
  logic [GID_W-1:0]         o_Grant_Id;
`ifdef FIFO_ARB_UNDERFLOW_ERR_EN
  logic                     o_Underflow;
  logic [7:0]               o_Underflow_Cnt;
`endif

  // Environment side: requesters, consumer and RAM.
  modport master (
    output i_Req_Valid, i_Req_Data, i_RD_En,
    input  o_Req_Ready, o_WR_En, o_WR_Addr, o_WR_Data, o_RD_Addr,
           o_Full, o_Empty, o_Count, o_Grant_Id
`ifdef FIFO_ARB_UNDERFLOW_ERR_EN
           , o_Underflow, o_Underflow_Cnt
`endif
  );

  // Controller side.
  modport slave (
    input  i_Req_Valid, i_Req_Data, i_RD_En,
    output o_Req_Ready, o_WR_En, o_WR_Addr, o_WR_Data, o_RD_Addr,
           o_Full, o_Empty, o_Count, o_Grant_Id
`ifdef FIFO_ARB_UNDERFLOW_ERR_EN
           , o_Underflow, o_Underflow_Cnt
`endif
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// One-hot round-robin grant with a last-grant register updated on accept.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic                            grant_en_i,
  output logic [NUM_REQ-1:0]              grant_oh_o,
  output logic [gid_w(NUM_REQ)-1:0]       grant_id_o,
  output logic                            accept_o
);

  localparam int unsigned GID_W = gid_w(NUM_REQ);

  logic [GID_W-1:0] last_q;
  logic [GID_W-1:0] last_d;
  logic             found;
  int unsigned      idx;
  logic [GID_W-1:0] cand;

  // Search from last_q+1 (mod NUM_REQ) for the first valid requester.
  always_comb begin
    grant_oh_o = '0;
    grant_id_o = '0;
    found      = 1'b0;
    idx        = 0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx  = (32'(last_q) + 32'd1 + i) % NUM_REQ;
      cand = GID_W'(idx);
      if (!found && req_valid_i[cand]) begin
        found      = 1'b1;
        grant_id_o = cand;
        if (grant_en_i) begin
          grant_oh_o[cand] = 1'b1;
        end
      end
    end
  end

  assign accept_o = |(grant_oh_o & req_valid_i);
  assign last_d   = accept_o ? grant_id_o : last_q;

  // Last-grant register; idle cycles leave it untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= GID_W'(rr_reset_last(NUM_REQ));
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// FIFO write-port controller: round-robin requester arbitration, pointers and status.
// Optional: FIFO_ARB_UNDERFLOW_ERR_EN adds sticky underflow flag and saturating counter.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  fifo_wr_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned GID_W = gid_w(NUM_REQ);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic [NUM_REQ-1:0] grant_oh;
  logic [GID_W-1:0]   grant_id;
  logic               push;
  logic               pop;
  logic [WIDTH-1:0]   wr_data;

  // Grants are suppressed while full or in reset.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk_i       (i_Clk),
    .rst_ni      (i_Rst_n),
    .req_valid_i (bus.i_Req_Valid),
    .grant_en_i  (i_Rst_n & ~full_q),
    .grant_oh_o  (grant_oh),
    .grant_id_o  (grant_id),
    .accept_o    (push)
  );

  // Select the winning requester's data word.
  always_comb begin
    wr_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (GID_W'(k) == grant_id) begin
        wr_data = bus.i_Req_Data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign pop = bus.i_RD_En & ~empty_q;

  // Next pointers and status derived from the post-edge pointer pair.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    full_d   = (wr_ptr_d[DEPTH] != rd_ptr_d[DEPTH]) &&
               (wr_ptr_d[DEPTH-1:0] == rd_ptr_d[DEPTH-1:0]);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    count_d  = wr_ptr_d - rd_ptr_d;
  end

  // Pointer and status registers.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign bus.o_Req_Ready = grant_oh;
  assign bus.o_WR_En     = push;
  assign bus.o_WR_Data   = wr_data;
  assign bus.o_Grant_Id  = grant_id;
  assign bus.o_WR_Addr   = wr_ptr_q[DEPTH-1:0];
  assign bus.o_RD_Addr   = rd_ptr_q[DEPTH-1:0];
  assign bus.o_Full      = full_q;
  assign bus.o_Empty     = empty_q;
  assign bus.o_Count     = count_q;

`ifdef FIFO_ARB_UNDERFLOW_ERR_EN
  logic       underflow_q;
  logic [7:0] underflow_cnt_q;

  // Sticky flag and saturating count of reads attempted while empty.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      underflow_q     <= 1'b0;
      underflow_cnt_q <= '0;
    end else if (bus.i_RD_En && empty_q) begin
      underflow_q <= 1'b1;
      if (underflow_cnt_q != 8'hFF) begin
        underflow_cnt_q <= underflow_cnt_q + 8'd1;
      end
    end
  end

  assign bus.o_Underflow     = underflow_q;
  assign bus.o_Underflow_Cnt = underflow_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a queue-based reference model.
module tb_fifo_wr_arbiter;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned NUM_REQ = 4;
  localparam int          SIZE    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ)) bus ();

  fifo_wr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  // Behavioural RAM: write on edge, combinational read.
  logic [WIDTH-1:0] ram [SIZE];
  always @(posedge clk) begin
    if (bus.o_WR_En) ram[bus.o_WR_Addr] <= bus.o_WR_Data;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [7:0] mq[$];
  int         last_g = NUM_REQ - 1;
  int         n_push = 0;
  int         n_pop  = 0;
  bit         uf     = 1'b0;
  int         uf_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check combinational/registered outputs, advance model.
  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic rd, input logic rs);
    int win;
    int cnt;
    @(negedge clk);
    bus.i_Req_Valid = v;
    bus.i_Req_Data  = d;
    bus.i_RD_En     = rd;
    rst_n           = rs;
    #1;
    cnt = mq.size();
    win = -1;
    if (rs && cnt < SIZE) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int k;
        k = (last_g + 1 + i) % NUM_REQ;
        if (win < 0 && v[k]) win = k;
      end
    end
    check("ready", 32'(bus.o_Req_Ready), (win < 0) ? 32'd0 : (32'd1 << win));
    check("wr_en", 32'(bus.o_WR_En), 32'(win >= 0));
    if (win >= 0) begin
      check("grant_id", 32'(bus.o_Grant_Id), 32'(win));
      check("wr_data", 32'(bus.o_WR_Data), 32'(d[win*8 +: 8]));
      check("wr_addr", 32'(bus.o_WR_Addr), 32'(n_push % SIZE));
    end
    check("count", 32'(bus.o_Count), 32'(cnt));
    check("full", 32'(bus.o_Full), 32'(cnt == SIZE));
    check("empty", 32'(bus.o_Empty), 32'(cnt == 0));
    check("rd_addr", 32'(bus.o_RD_Addr), 32'(n_pop % SIZE));
    if (cnt > 0) check("head", 32'(ram[bus.o_RD_Addr]), 32'(mq[0]));
`ifdef FIFO_ARB_UNDERFLOW_ERR_EN
    check("underflow", 32'(bus.o_Underflow), 32'(uf));
    check("underflow_cnt", 32'(bus.o_Underflow_Cnt), 32'(uf_cnt));
`endif
    @(posedge clk);
    if (!rs) begin
      mq.delete();
      last_g = NUM_REQ - 1;
      n_push = 0;
      n_pop  = 0;
      uf     = 1'b0;
      uf_cnt = 0;
    end else begin
      if (rd && cnt > 0) begin
        void'(mq.pop_front());
        n_pop++;
      end else if (rd) begin
        uf = 1'b1;
        if (uf_cnt < 255) uf_cnt++;
      end
      if (win >= 0) begin
        mq.push_back(d[win*8 +: 8]);
        last_g = win;
        n_push++;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * SIZE && mq.size() > 0; i++) step(4'b0000, 32'd0, 1'b1, 1'b1);
    check("drained", 32'(mq.size()), 32'd0);
  endtask

  initial begin
    bus.i_Req_Valid = '0;
    bus.i_Req_Data  = '0;
    bus.i_RD_En     = 1'b0;
    repeat (2) @(posedge clk);

    // Reset, idle, then three reads while empty.
    step(4'b0000, 32'd0, 1'b0, 1'b0);
    step(4'b0000, 32'd0, 1'b0, 1'b1);
    repeat (3) step(4'b0000, 32'd0, 1'b1, 1'b1);
    #1;
    check("rd_ptr_after_empty_reads", 32'(bus.o_RD_Addr), 32'd0);
`ifdef FIFO_ARB_UNDERFLOW_ERR_EN
    check("uf_cnt_3", 32'(bus.o_Underflow_Cnt), 32'd3);
`endif

    // All four valid until full.
    repeat (SIZE) step(4'b1111, $urandom, 1'b0, 1'b1);
    #1;
    check("fill_count", 32'(bus.o_Count), 32'd16);
    check("fill_full", 32'(bus.o_Full), 32'd1);
    step(4'b1111, $urandom, 1'b0, 1'b1);

    // Pop while full: only the pop happens, then requester 0 wins.
    step(4'b1111, $urandom, 1'b1, 1'b1);
    #1;
    check("after_pop_count", 32'(bus.o_Count), 32'd15);
    check("after_pop_full", 32'(bus.o_Full), 32'd0);
    step(4'b1111, $urandom, 1'b0, 1'b1);
    drain();

    // Only requester 2, then requesters 1 and 3.
    repeat (3) step(4'b0100, $urandom, 1'b0, 1'b1);
    repeat (2) step(4'b1010, $urandom, 1'b0, 1'b1);
    drain();

    // Push into empty with simultaneous read: no pop.
    step(4'b0010, 32'h0000_A500, 1'b1, 1'b1);
    #1;
    check("a5_count", 32'(bus.o_Count), 32'd1);
    check("a5_head", 32'(ram[bus.o_RD_Addr]), 32'h0000_00A5);
    step(4'b0010, 32'h0000_3C00, 1'b1, 1'b1);
    #1;
    check("push_pop_count", 32'(bus.o_Count), 32'd1);
    step(4'b0000, 32'd0, 1'b0, 1'b1);

    // Random burst, then reset mid-burst.
    repeat (40) step(4'($urandom), $urandom, 1'($urandom), 1'b1);
    step(4'($urandom), $urandom, 1'($urandom), 1'b0);
    #1;
    check("mid_reset_count", 32'(bus.o_Count), 32'd0);
    check("mid_reset_empty", 32'(bus.o_Empty), 32'd1);

    // Longer random run, biased toward pushes so full is reached.
    for (int i = 0; i < 300; i++) begin
      step(4'($urandom), $urandom, 1'($urandom_range(0, 3) == 0), 1'b1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
